// File: rtl/vertex_rotate_seq.sv
// Sequential two-angle vertex rotation with a screen-space offset: one MAC term per cycle, result on the 9th edge after accept.
// Define ROT_SAT_EN to saturate sx/sy/depth to 16 bits; otherwise they wrap.
module vertex_rotate_seq #(
  parameter int X_OFF = 320,
  parameter int Y_OFF = 240
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [15:0]  vx,
  input  logic signed [15:0]  vy,
  input  logic signed [15:0]  vz,
  input  logic signed [15:0]  sin_a,
  input  logic signed [15:0]  cos_a,
  input  logic signed [15:0]  sin_b,
  input  logic signed [15:0]  cos_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [15:0]  sx,
  output logic signed [15:0]  sy,
  output logic signed [15:0]  depth,
  output logic                busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned PW = 48;
  localparam int unsigned IW = 4;

  localparam logic signed [DW-1:0] ONE_D   = 16'sd10000;
  localparam logic signed [PW-1:0] SCALE_P = 48'sd10000;
  localparam logic signed [AW-1:0] SCALE_A = 32'sd10000;
  localparam logic signed [AW-1:0] XO      = 32'(X_OFF);
  localparam logic signed [AW-1:0] YO      = 32'(Y_OFF);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0] rx, ry, rz, rsa, rca, rsb, rcb;
  logic signed [DW-1:0] rx_nxt, ry_nxt, rz_nxt, rsa_nxt, rca_nxt, rsb_nxt, rcb_nxt;
  logic signed [AW-1:0] acc_x, acc_y, acc_z;
  logic signed [AW-1:0] acc_x_nxt, acc_y_nxt, acc_z_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic signed [DW-1:0] sx_nxt, sy_nxt, depth_nxt;
  logic                 out_valid_nxt, in_ready_nxt, busy_nxt;

  logic signed [DW-1:0] op_p, op_q, op_r;
  logic [1:0]           op_tgt;
  logic                 op_neg;
  logic signed [PW-1:0] prod, quot;
  logic signed [AW-1:0] term, sterm;
  logic signed [AW-1:0] xr, yr, zr;

  function automatic logic signed [DW-1:0] fit16(input logic signed [AW-1:0] v);
`ifdef ROT_SAT_EN
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return 16'(v);
`else
    return 16'(v);
`endif
  endfunction

  // Operand and destination for the term at the current index
  always_comb begin
    op_p   = rx;
    op_q   = rcb;
    op_r   = ONE_D;
    op_tgt = 2'd0;
    op_neg = 1'b0;
    case (idx[2:0])
      3'd0: begin op_p = rx; op_q = rcb; op_r = ONE_D; op_tgt = 2'd0; end
      3'd1: begin op_p = ry; op_q = rsa; op_r = rsb;   op_tgt = 2'd0; end
      3'd2: begin op_p = rz; op_q = rca; op_r = rsb;   op_tgt = 2'd0; end
      3'd3: begin op_p = ry; op_q = rca; op_r = ONE_D; op_tgt = 2'd1; end
      3'd4: begin op_p = rz; op_q = rsa; op_r = ONE_D; op_tgt = 2'd1; op_neg = 1'b1; end
      3'd5: begin op_p = rx; op_q = rsb; op_r = ONE_D; op_tgt = 2'd2; op_neg = 1'b1; end
      3'd6: begin op_p = ry; op_q = rsa; op_r = rcb;   op_tgt = 2'd2; end
      default: begin op_p = rz; op_q = rca; op_r = rcb; op_tgt = 2'd2; end
    endcase
  end

  // 48-bit signed triple product; signed division truncates toward zero
  assign prod  = PW'(op_p) * PW'(op_q) * PW'(op_r);
  assign quot  = prod / SCALE_P;
  assign term  = AW'(quot);
  assign sterm = op_neg ? -term : term;

  assign xr = acc_x / SCALE_A;
  assign yr = acc_y / SCALE_A;
  assign zr = acc_z / SCALE_A;

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state;
    rx_nxt        = rx;
    ry_nxt        = ry;
    rz_nxt        = rz;
    rsa_nxt       = rsa;
    rca_nxt       = rca;
    rsb_nxt       = rsb;
    rcb_nxt       = rcb;
    acc_x_nxt     = acc_x;
    acc_y_nxt     = acc_y;
    acc_z_nxt     = acc_z;
    idx_nxt       = idx;
    sx_nxt        = sx;
    sy_nxt        = sy;
    depth_nxt     = depth;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          rx_nxt    = vx;
          ry_nxt    = vy;
          rz_nxt    = vz;
          rsa_nxt   = sin_a;
          rca_nxt   = cos_a;
          rsb_nxt   = sin_b;
          rcb_nxt   = cos_b;
          acc_x_nxt = '0;
          acc_y_nxt = '0;
          acc_z_nxt = '0;
          idx_nxt   = '0;
          state_nxt = MAC;
        end
      end
      MAC: begin
        if (idx[3]) begin
          sx_nxt        = fit16(xr + XO);
          sy_nxt        = fit16(YO - yr);
          depth_nxt     = fit16(zr);
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          case (op_tgt)
            2'd0:    acc_x_nxt = acc_x + sterm;
            2'd1:    acc_y_nxt = acc_y + sterm;
            default: acc_z_nxt = acc_z + sterm;
          endcase
          idx_nxt = idx + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt = (state_nxt == IDLE);
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx        <= '0;
      ry        <= '0;
      rz        <= '0;
      rsa       <= '0;
      rca       <= '0;
      rsb       <= '0;
      rcb       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_z     <= '0;
      idx       <= '0;
      sx        <= '0;
      sy        <= '0;
      depth     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx        <= rx_nxt;
      ry        <= ry_nxt;
      rz        <= rz_nxt;
      rsa       <= rsa_nxt;
      rca       <= rca_nxt;
      rsb       <= rsb_nxt;
      rcb       <= rcb_nxt;
      acc_x     <= acc_x_nxt;
      acc_y     <= acc_y_nxt;
      acc_z     <= acc_z_nxt;
      idx       <= idx_nxt;
      sx        <= sx_nxt;
      sy        <= sy_nxt;
      depth     <= depth_nxt;
      out_valid <= out_valid_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: doc/vertex_rotate_seq.md
VERTEX_ROTATE_SEQ -- requirements
Module: vertex_rotate_seq

Interface
REQ-001 Parameter X_OFF, default 320, signed screen-x offset added to rotated x.
REQ-002 Parameter Y_OFF, default 240, signed screen-y offset from which rotated y is subtracted.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  vertex/angle set offered.
REQ-006 in_ready  output  1  block accepts a set this cycle.
REQ-007 vx, vy, vz  input  16 each  signed vertex coordinates.
REQ-008 sin_a, cos_a, sin_b, cos_b  input  16 each  signed trig values scaled by 10000; range -10000..10000.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sx, sy, depth  output  16 each  signed screen x, screen y and rotated z.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Term definition: t(p,q,r) = (p*q*r)/10000, computed as a 48-bit signed product with division truncating toward zero.
REQ-014 States: IDLE, MAC, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept edge (IDLE, in_valid=1): register all inputs, clear acc_x, acc_y and acc_z (32-bit signed), set term index 0, go to MAC.
REQ-016 Input changes after the accept edge have no effect on the current result.
REQ-017 MAC accumulates one term per edge at index 0..7, in this fixed order: acc_x += t(x,cb,10000); acc_x += t(y,sa,sb); acc_x += t(z,ca,sb); acc_y += t(y,ca,10000); acc_y -= t(z,sa,10000); acc_z -= t(x,sb,10000); acc_z += t(y,sa,cb); acc_z += t(z,ca,cb).
REQ-018 Edge after index 7: xr = acc_x/10000, yr = acc_y/10000, zr = acc_z/10000, all truncating toward zero.
REQ-019 On that same edge the block registers sx = xr+X_OFF, sy = Y_OFF-yr and depth = zr, sets out_valid = 1 and goes to DONE.
REQ-020 Latency: out_valid is high after the 9th edge following the accept edge.
REQ-021 DONE holds sx, sy, depth and out_valid stable until out_valid & out_ready at an edge; that edge clears out_valid and returns to IDLE.
REQ-022 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.
REQ-023 Minimum initiation interval is 11 cycles (accept, 8 MAC cycles, result cycle, handshake cycle).

Reset
REQ-024 rst_n low, asynchronously and in any state including mid-MAC: state = IDLE; out_valid = 0; sx, sy and depth = 0; accumulators and index = 0; busy = 0.
REQ-025 The first accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro ROT_SAT_EN defined: sx, sy and depth saturate to -32768..32767, computed from the 32-bit intermediate.
REQ-027 Macro ROT_SAT_EN undefined: sx, sy and depth are the low 16 bits of the intermediate (two's-complement wrap).

Verification
REQ-028 v=(100,0,0), sa=sb=0, ca=cb=10000 -> sx=420, sy=240, depth=0; out_valid on the 9th edge after accept.
REQ-029 v=(100,0,0), sa=0, ca=10000, sb=10000, cb=0 -> sx=320, sy=240, depth=-100.
REQ-030 v=(-3,0,0), cb=3333, ca=10000, sa=sb=0 -> sx=320, which checks truncation toward zero.
REQ-031 v=(32700,0,0), identity angles, X_OFF=320 -> sx=32767 with ROT_SAT_EN; sx=-32516 without it.
REQ-032 out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; return to IDLE on the first out_ready edge.
REQ-033 rst_n pulsed low at MAC index 4 -> outputs cleared immediately; a following transaction produces the correct result.
